// File: rtl/regfile_block_mover.sv
// regfile_block_mover: memmove-style block copier driving a 64-entry register file port pair
//   clk, rst                       : clock, synchronous active-high reset
//   start, src_addr, dst_addr, len : copy request, sampled in IDLE; len clamps to the file depth
//   busy, done                     : copy in progress / one-cycle completion pulse
//   rd_addr, rd_data               : register-file read port (rd_data is combinational)
//   wr_en, wr_addr, wr_data        : register-file write port (wr_data = rd_data)
module regfile_block_mover #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);
    localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] src_cur, dst_cur, diff, src_first, dst_first;
    logic [ADDR_WIDTH:0]   cnt, len_c;
    logic                  desc, desc_nx, accept;

    assign accept  = (state == IDLE) && start;
    assign len_c   = (len > DEPTH) ? DEPTH : len;
    assign diff    = dst_addr - src_addr;
    // A destination that starts inside the source block must be filled from the top down
    assign desc_nx = ({1'b0, diff} < len_c) && (dst_addr != src_addr);
    assign src_first = desc_nx ? src_addr + len_c[ADDR_WIDTH-1:0] - STEP : src_addr;
    assign dst_first = desc_nx ? dst_addr + len_c[ADDR_WIDTH-1:0] - STEP : dst_addr;

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = (len_c == '0) ? DONE : COPY;
        else if (state == COPY && cnt == CNT_ONE)
            state_nx = DONE;
        else if (state == DONE)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_cur <= '0;
            dst_cur <= '0;
            cnt     <= '0;
            desc    <= 1'b0;
        end else if (accept) begin
            src_cur <= src_first;
            dst_cur <= dst_first;
            cnt     <= len_c;
            desc    <= desc_nx;
        end else if (state == COPY) begin
            src_cur <= desc ? src_cur - STEP : src_cur + STEP;
            dst_cur <= desc ? dst_cur - STEP : dst_cur + STEP;
            cnt     <= cnt - CNT_ONE;
        end
    end

    assign busy    = (state == COPY);
    assign done    = (state == DONE);
    assign rd_addr = src_cur;
    assign wr_addr = dst_cur;
    assign wr_data = rd_data;
    // Register 0 is hardwired, so its slot is skipped; rst also suppresses the in-flight write
    assign wr_en   = busy && (dst_cur != '0) && !rst;
endmodule

// File: tb/tb_regfile_block_mover.sv
// tb_regfile_block_mover: directed and random block copies checked against a memmove model
module tb_regfile_block_mover;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, ld = 1'b0;
    logic [5:0] src_addr = '0, dst_addr = '0;
    logic [6:0] len = '0;
    logic       busy, done, wr_en;
    logic [5:0] rd_addr, wr_addr;
    logic [7:0] rd_data, wr_data;
    logic [7:0] rf [64];
    logic [7:0] ld_img [64];
    int         wr_log [$];
    int         rd_log [$];
    int         vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    regfile_block_mover dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    assign rd_data = (rd_addr == 6'd0) ? 8'd0 : rf[rd_addr];

    always @(posedge clk) begin
        if (ld)
            rf <= ld_img;
        else if (wr_en)
            rf[wr_addr] <= wr_data;
        if (wr_en)
            wr_log.push_back(int'(wr_addr));
        if (busy)
            rd_log.push_back(int'(rd_addr));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++)
            ld_img[i] = (i == 0) ? 8'd0 : 8'($urandom);
    endtask

    // Expected contents: every destination word takes the source word as it was before the copy
    task automatic run_copy(input string tag, input int s, input int d, input int l, input bit poke);
        logic [7:0] exp [64];
        int lc, ew, cyc, nb, bad;
        lc = (l > 64) ? 64 : l;
        exp = ld_img;
        ew = 0;
        for (int i = 0; i < lc; i++) begin
            int a, b;
            a = (d + i) % 64;
            b = (s + i) % 64;
            if (a != 0) begin
                exp[a] = ld_img[b];
                ew++;
            end
        end
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
        bad = wr_log.size();
        start = 1'b1; src_addr = 6'(s); dst_addr = 6'(d); len = 7'(l);
        @(posedge clk); #1;
        start = 1'b0;
        src_addr = 6'(d); dst_addr = 6'(s);
        cyc = 0; nb = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) nb++;
            start = poke && (cyc == 1);
            @(posedge clk); #1;
            cyc++;
        end
        ew = ew - (wr_log.size() - bad);
        start = poke;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("%s/cycles", tag), cyc, lc);
        chk($sformatf("%s/busy", tag), nb, lc);
        chk($sformatf("%s/writes_left", tag), ew, 0);
        chk($sformatf("%s/after_done", tag), {30'd0, done, busy}, 0);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (rf[i] !== exp[i]) bad++;
        chk($sformatf("%s/mem", tag), bad, 0);
    endtask

    initial begin
        int wb, rb, s, d, l, dd, mx;
        bit seen;
        int ord [4];
        repeat (2) @(posedge clk); #1;
        chk("reset/busy", busy, 0);
        chk("reset/done", done, 0);
        chk("reset/wr_en", wr_en, 0);
        chk("reset/rd_addr", rd_addr, 0);
        chk("reset/wr_addr", wr_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill_rand();
        ld_img[4] = 8'hA1; ld_img[5] = 8'hA2; ld_img[6] = 8'hA3;
        run_copy("fwd", 4, 20, 3, 1'b0);
        chk("fwd/rf20", rf[20], 8'hA1);
        chk("fwd/rf22", rf[22], 8'hA3);

        fill_rand();
        for (int i = 0; i < 4; i++) ld_img[10 + i] = 8'(i + 1);
        wb = wr_log.size();
        run_copy("ovl", 10, 12, 4, 1'b0);
        ord = '{15, 14, 13, 12};
        for (int i = 0; i < 4; i++)
            chk($sformatf("ovl/order%0d", i), wr_log[wb + i], ord[i]);
        for (int i = 0; i < 4; i++)
            chk($sformatf("ovl/rf%0d", 12 + i), rf[12 + i], i + 1);

        fill_rand();
        ld_img[62] = 8'd9; ld_img[63] = 8'd8; ld_img[1] = 8'd7;
        rb = rd_log.size();
        run_copy("wrap", 62, 2, 4, 1'b0);
        ord = '{62, 63, 0, 1};
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap/rd%0d", i), rd_log[rb + i], ord[i]);
        chk("wrap/rf4", rf[4], 0);

        fill_rand();
        wb = wr_log.size();
        run_copy("dst0", 8, 63, 3, 1'b0);
        chk("dst0/nwr", wr_log.size() - wb, 2);
        chk("dst0/wr0", wr_log[wb], 63);
        chk("dst0/wr1", wr_log[wb + 1], 1);

        fill_rand();
        run_copy("len0", 3, 9, 0, 1'b0);
        wb = wr_log.size();
        run_copy("len100", 7, 7, 100, 1'b0);
        chk("len100/nwr", wr_log.size() - wb, 63);

        fill_rand();
        run_copy("poke", 17, 50, 6, 1'b1);

        fill_rand();
        wb = wr_log.size();
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
        start = 1'b1; src_addr = 6'd30; dst_addr = 6'd40; len = 7'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst/wr_en", wr_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst/busy", busy, 0);
        chk("rst/nwr", wr_log.size() - wb, 2);
        chk("rst/rf40", rf[40], ld_img[30]);
        chk("rst/rf41", rf[41], ld_img[31]);
        chk("rst/rf42", rf[42], ld_img[42]);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen = 1'b1;
        end
        chk("rst/no_done", seen, 0);

        for (int k = 0; k < 24; k++) begin
            s = int'($urandom_range(0, 63));
            d = int'($urandom_range(0, 63));
            dd = (d - s + 64) % 64;
            mx = (dd == 0) ? 100 : ((dd > 64 - dd) ? dd : 64 - dd);
            l = int'($urandom_range(0, mx));
            fill_rand();
            run_copy($sformatf("rnd%0d", k), s, d, l, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
